uart_rx_fifo: RTL and testbench

- Receive-side buffer between the UART receiver core and the APB register block. Everything runs in the `clk` domain.
- Detects completion of each received character from the receiver's `rx_done` level and captures `rx_data` with its `parity_error` tag into a first-word-fall-through FIFO.
- Gives the register block a pop interface plus status: empty, full, count, almost-full and a sticky overflow flag.
- The almost-full flag lets the top level hold off the remote transmitter through RTS.

---
 rtl/uart_rx_fifo_pkg.sv | 12 +
 rtl/uart_rx_fifo_if.sv | 34 +++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_rx_fifo.sv | 82 ++++++++
 tb/tb_uart_rx_fifo.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared types and default sizing for the UART receive FIFO
package uart_fifo_pkg;

  typedef struct packed {
    logic       perr;
    logic [7:0] data;
  } uart_rx_entry_t;

  localparam int UART_RX_FIFO_DEPTH_DEF = 16;
  localparam int UART_RX_FIFO_AF_DEF    = 12;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side and register-side signals of the UART receive FIFO
interface uart_rx_fifo_if
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = UART_RX_FIFO_DEPTH_DEF
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic              parity_error;
  logic              pop;
  logic              clr_overflow;
  logic [DATA_W-1:0] rd_data;
  logic              rd_perr;
  logic              empty;
  logic              full;
  logic [CW-1:0]     count;
  logic              almost_full;
  logic              overflow;
  logic [7:0]        perr_drop_cnt;

  modport master (
    output rx_data, rx_done, parity_error, pop, clr_overflow,
    input  rd_data, rd_perr, empty, full, count, almost_full, overflow, perr_drop_cnt
  );

  modport slave (
    input  rx_data, rx_done, parity_error, pop, clr_overflow,
    output rd_data, rd_perr, empty, full, count, almost_full, overflow, perr_drop_cnt
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - generic synchronous first-word-fall-through FIFO with occupancy count
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // A pop frees the slot the same edge, so a full FIFO still accepts a concurrent write.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive buffer: rx_done edge capture, FWFT FIFO, status flags
// Optional parity-error discard enabled by defining UART_RX_FIFO_PERR_DROP_EN.
module uart_rx_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH    = UART_RX_FIFO_DEPTH_DEF,
  parameter int DATA_W   = 8,
  parameter int AF_LEVEL = UART_RX_FIFO_AF_DEF
) (
  input logic           clk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);

  logic              rx_done_q;
  logic              push_req;
  logic              store_req;
  logic              wr_perr;
  logic              overflow_q;
  logic              fifo_full;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W:0]   head;

  // rx_done idles high, so a rising edge marks a freshly completed character.
  assign push_req = bus.rx_done & ~rx_done_q;

`ifdef UART_RX_FIFO_PERR_DROP_EN
  logic [7:0] perr_cnt_q;

  assign store_req = push_req & ~bus.parity_error;
  assign wr_perr   = 1'b0;
  assign bus.perr_drop_cnt = perr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_cnt_q <= '0;
    end else if (push_req && bus.parity_error && perr_cnt_q != 8'hFF) begin
      perr_cnt_q <= perr_cnt_q + 8'd1;
    end
  end
`else
  assign store_req = push_req;
  assign wr_perr   = bus.parity_error;
  assign bus.perr_drop_cnt = '0;
`endif

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (store_req),
    .wr_data ({wr_perr, bus.rx_data}),
    .rd_en   (bus.pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (bus.empty)
  );

  assign bus.rd_data     = head[DATA_W-1:0];
  assign bus.rd_perr     = head[DATA_W];
  assign bus.count       = fifo_count;
  assign bus.full        = fifo_full;
  assign bus.almost_full = (fifo_count >= AF_CNT);
  assign bus.overflow    = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_done_q  <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      rx_done_q <= bus.rx_done;
      if (store_req && fifo_full && !bus.pop) overflow_q <= 1'b1;
      else if (bus.clr_overflow)              overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  import uart_fifo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

  uart_rx_fifo #(.DEPTH(16), .DATA_W(8), .AF_LEVEL(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] d, input logic perr, input logic with_pop, input logic with_clr);
    bus.rx_data = d;
    bus.parity_error = perr;
    bus.rx_done = 1'b0;
    tick();
    bus.rx_done = 1'b1;
    bus.pop = with_pop;
    bus.clr_overflow = with_clr;
    tick();
    bus.pop = 1'b0;
    bus.clr_overflow = 1'b0;
    bus.parity_error = 1'b0;
  endtask

  task automatic do_pop();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0d want 1", bus.empty); end
    n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %0h want 0", bus.rd_data); end
    n_checks++; if (bus.rd_perr !== 1'b0) begin n_fail++; $display("FAIL reset_rd_perr: got %0d want 0", bus.rd_perr); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0d want 0", bus.full); end
    n_checks++; if (bus.perr_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_perr_cnt: got %0d want 0", bus.perr_drop_cnt); end
    repeat (10) tick();
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL idle_empty: got %0d want 1", bus.empty); end
    n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL idle_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL idle_overflow: got %0d want 0", bus.overflow); end
    n_checks++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL idle_af: got %0d want 0", bus.almost_full); end
  endtask

  task automatic test_order();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      send_char(exp_d[i], 1'b0, 1'b0, 1'b0);
      n_checks++; if (bus.count !== 5'(i + 1)) begin n_fail++; $display("FAIL order_count_up%0d: got %0d want %0d", i, bus.count, i + 1); end
      n_checks++; if (bus.rd_data !== 8'h41) begin n_fail++; $display("FAIL order_head%0d: got %0h want 41", i, bus.rd_data); end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.rd_data !== exp_d[i]) begin n_fail++; $display("FAIL order_rd%0d: got %0h want %0h", i, bus.rd_data, exp_d[i]); end
      do_pop();
      n_checks++; if (bus.count !== 5'(2 - i)) begin n_fail++; $display("FAIL order_count_dn%0d: got %0d want %0d", i, bus.count, 2 - i); end
    end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL order_empty: got %0d want 1", bus.empty); end
    n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL order_rd_empty: got %0h want 0", bus.rd_data); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      send_char(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      if (i == 10) begin
        n_checks++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL af_at11: got %0d want 0", bus.almost_full); end
      end
      if (i == 11) begin
        n_checks++; if (bus.almost_full !== 1'b1) begin n_fail++; $display("FAIL af_at12: got %0d want 1", bus.almost_full); end
      end
      if (i == 14) begin
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL full_at15: got %0d want 0", bus.full); end
      end
    end
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_at16: got %0d want 1", bus.full); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %0d want 0", bus.overflow); end
    send_char(8'hEE, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0d want 1", bus.overflow); end
    n_checks++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", bus.count); end
    n_checks++; if (bus.rd_data !== 8'h10) begin n_fail++; $display("FAIL ovf_head: got %0h want 10", bus.rd_data); end
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %0d want 0", bus.overflow); end
    send_char(8'hEF, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_priority: got %0d want 1", bus.overflow); end
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr2: got %0d want 0", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    send_char(8'hA5, 1'b0, 1'b1, 1'b0);
    n_checks++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL fpp_count: got %0d want 16", bus.count); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow: got %0d want 0", bus.overflow); end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 8'hA5 : 8'(8'h11 + i);
      n_checks++; if (bus.rd_data !== exp) begin n_fail++; $display("FAIL fpp_drain%0d: got %0h want %0h", i, bus.rd_data, exp); end
      do_pop();
    end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty: got %0d want 1", bus.empty); end
  endtask

  task automatic test_parity();
    uart_rx_entry_t exp_e;
    exp_e.perr = 1'b1;
    exp_e.data = 8'h55;
    send_char(exp_e.data, exp_e.perr, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_PERR_DROP_EN
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL perr_drop_empty: got %0d want 1", bus.empty); end
    n_checks++; if (bus.perr_drop_cnt !== 8'd1) begin n_fail++; $display("FAIL perr_drop_cnt: got %0d want 1", bus.perr_drop_cnt); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL perr_drop_ovf: got %0d want 0", bus.overflow); end
`else
    n_checks++; if ({bus.rd_perr, bus.rd_data} !== exp_e) begin n_fail++; $display("FAIL perr_entry: got %0h want %0h", {bus.rd_perr, bus.rd_data}, exp_e); end
    n_checks++; if (bus.perr_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL perr_cnt_tied: got %0d want 0", bus.perr_drop_cnt); end
    do_pop();
    n_checks++; if (bus.rd_perr !== 1'b0) begin n_fail++; $display("FAIL perr_after_pop: got %0d want 0", bus.rd_perr); end
`endif
  endtask

  task automatic test_empty_edges();
    do_pop();
    n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL pop_empty_count: got %0d want 0", bus.count); end
    send_char(8'h3C, 1'b0, 1'b1, 1'b0);
    n_checks++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL pp_empty_count: got %0d want 1", bus.count); end
    n_checks++; if (bus.rd_data !== 8'h3C) begin n_fail++; $display("FAIL pp_empty_data: got %0h want 3c", bus.rd_data); end
    do_pop();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send_char(8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.count !== 5'd5) begin n_fail++; $display("FAIL mid_fill: got %0d want 5", bus.count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %0d want 1", bus.empty); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf: got %0d want 0", bus.overflow); end
    n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL mid_rd: got %0h want 0", bus.rd_data); end
    tick();
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_no_spurious: got %0d want 1", bus.empty); end
    send_char(8'h77, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL mid_push_count: got %0d want 1", bus.count); end
    n_checks++; if (bus.rd_data !== 8'h77) begin n_fail++; $display("FAIL mid_push_data: got %0h want 77", bus.rd_data); end
    do_pop();
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL mid_final_empty: got %0d want 1", bus.empty); end
  endtask

  initial begin
    reset = 1'b1;
    bus.rx_data = '0;
    bus.rx_done = 1'b1;
    bus.parity_error = 1'b0;
    bus.pop = 1'b0;
    bus.clr_overflow = 1'b0;
    test_reset();
    test_order();
    test_fill_overflow();
    test_full_push_pop();
    test_parity();
    test_empty_edges();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
